load_store_unit: RTL and testbench

Multi-cycle load/store unit for the RV32I core, directly downstream of the ALU: it takes the ALU result as the effective address, drives a request/grant data-memory bus, and returns sign- or zero-extended load data to writeback. While an access is outstanding it stalls the core through `busy_o`. It also flags misaligned or illegal accesses without touching the bus.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 83 ++++++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign codes and FSM states.
package lsu_pkg;

    // RV32I funct3 codes for loads/stores. Bits [1:0] encode the access size,
    // bit 2 selects zero-extension on loads.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size field (funct3[1:0]).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting for the load/store unit.
// Request side: store data replication, byte enables and the fault check,
// evaluated on the instruction being accepted.
// Response side: byte/halfword extraction and extension of the returned word,
// evaluated on the registered offset and funct3 of the access in flight.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           req_is_store_i,
    input  logic [2:0]     req_funct3_i,
    input  logic [1:0]     req_offset_i,
    input  logic [LEN-1:0] req_wdata_i,
    output logic [LEN-1:0] req_wdata_o,
    output logic [3:0]     req_be_o,
    output logic           req_fault_o,
    input  logic [2:0]     ld_funct3_i,
    input  logic [1:0]     ld_offset_i,
    input  logic [LEN-1:0] ld_word_i,
    output logic [LEN-1:0] ld_data_o
);

    logic [1:0] req_size;
    assign req_size = req_funct3_i[1:0];

    // Replicate the low byte/halfword into every lane so the memory only has
    // to honour the byte enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_wdata_o[gi*8 +: 8] =
                (req_size == SZ_BYTE) ? req_wdata_i[7:0] :
                (req_size == SZ_HALF) ? req_wdata_i[(gi % 2)*8 +: 8] :
                                        req_wdata_i[gi*8 +: 8];
        end
    endgenerate

    // Byte enables and fault detection (illegal funct3 or misaligned address).
    always_comb begin
        logic illegal;
        logic misaligned;
        illegal    = 1'b0;
        misaligned = 1'b0;
        req_be_o   = 4'b1111;
        if (req_is_store_i) begin
            illegal = req_funct3_i[2];
        end else begin
            illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
        end
        unique case (req_size)
            SZ_BYTE: begin
                req_be_o   = 4'b0001 << req_offset_i;
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                req_be_o   = req_offset_i[1] ? 4'b1100 : 4'b0011;
                misaligned = req_offset_i[0];
            end
            default: begin
                req_be_o   = 4'b1111;
                misaligned = (req_offset_i != 2'b00);
            end
        endcase
        req_fault_o = illegal | misaligned;
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = ld_word_i[{ld_offset_i, 3'b000} +: 8];
        half_sel = ld_offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        unique case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data_o = {24'h000000, byte_sel};
            F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data_o = {16'h0000, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access in flight, request/grant data bus,
// sign/zero-extended load return and fault reporting without bus traffic.
// Only LEN = 32 is supported.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_i,
    input  logic           is_store_i,
    input  logic [2:0]     funct3_i,
    input  logic [LEN-1:0] addr_i,
    input  logic [LEN-1:0] wdata_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [LEN-1:0] rdata_o,
    output logic           fault_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic [LEN-1:0] mem_addr_o,
    output logic [LEN-1:0] mem_wdata_o,
    output logic [3:0]     mem_be_o,
    input  logic           mem_gnt_i,
    input  logic           mem_rvalid_i,
    input  logic [LEN-1:0] mem_rdata_i
);

    lsu_state_t     state_q,    state_d;
    logic [LEN-1:0] addr_q,     addr_d;
    logic [2:0]     funct3_q,   funct3_d;
    logic           is_store_q, is_store_d;
    logic [LEN-1:0] wdata_q,    wdata_d;
    logic [3:0]     be_q,       be_d;
    logic           fault_q,    fault_d;
    logic [LEN-1:0] rdata_q,    rdata_d;

    logic [LEN-1:0] req_wdata;
    logic [3:0]     req_be;
    logic           req_fault;
    logic [LEN-1:0] ld_data;

    lsu_align #(.LEN(LEN)) u_align (
        .req_is_store_i (is_store_i),
        .req_funct3_i   (funct3_i),
        .req_offset_i   (addr_i[1:0]),
        .req_wdata_i    (wdata_i),
        .req_wdata_o    (req_wdata),
        .req_be_o       (req_be),
        .req_fault_o    (req_fault),
        .ld_funct3_i    (funct3_q),
        .ld_offset_i    (addr_q[1:0]),
        .ld_word_i      (mem_rdata_i),
        .ld_data_o      (ld_data)
    );

    // State and access registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic. Bus fields are only loaded in IDLE, which keeps them
    // stable for the whole REQ phase. rvalid is honoured only in WAIT.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        fault_d    = fault_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    addr_d     = addr_i;
                    funct3_d   = funct3_i;
                    is_store_d = is_store_i;
                    wdata_d    = req_wdata;
                    be_d       = req_be;
                    fault_d    = req_fault;
                    rdata_d    = '0;
                    state_d    = req_fault ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = is_store_q ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = ld_data;
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core-facing handshake: busy drops in RESP so the core advances on that edge.
    assign busy_o  = ((state_q == ST_IDLE) && valid_i) ||
                     (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign done_o  = (state_q == ST_RESP);
    assign fault_o = (state_q == ST_RESP) && fault_q;
    assign rdata_o = rdata_q;

    // Bus outputs come straight from the access registers.
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = (state_q == ST_REQ) && is_store_q;
    assign mem_addr_o  = {addr_q[LEN-1:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a byte-addressed memory model and arithmetic expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_vec;
    int n_err;

    logic [31:0] mem_model [0:63];

    load_store_unit #(.LEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .fault_o      (fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit illegal;
        if (st) illegal = (f3 > 3);
        else    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
        return illegal || ((a % acc_bytes(f3)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        if (acc_bytes(f3) >= 4) return 4'hF;
        v = ((1 << acc_bytes(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (acc_bytes(f3) == 1) return {24'h0, w[7:0]} * 32'h01010101;
        if (acc_bytes(f3) == 2) return {16'h0, w[15:0]} * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] s;
        s = word >> (8 * (a % 4));
        case (f3)
            3'd0:    return 32'($signed(s[7:0]));
            3'd4:    return {24'h0, s[7:0]};
            3'd1:    return 32'($signed(s[15:0]));
            3'd5:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // One complete access: gd = extra REQ cycles before grant, rd = extra WAIT
    // cycles before rvalid, noise = spurious rvalid while not in WAIT.
    task automatic run_access(input string name, input bit st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gd, input int rd, input bit noise);
        bit          e_fault;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd, e_addr, word;
        int          done_cyc;
        bit          in_req;
        e_fault  = model_fault(st, f3, a);
        e_be     = model_be(f3, a);
        e_wd     = model_wdata(f3, wd);
        e_addr   = {a[31:2], 2'b00};
        word     = mem_model[a[7:2]];
        e_rd     = (st || e_fault) ? 32'h0 : model_load(f3, a, word);
        done_cyc = e_fault ? 1 : (st ? 2 + gd : 3 + gd + rd);

        @(negedge clk);
        valid_i      = 1'b1;
        is_store_i   = st;
        funct3_i     = f3;
        addr_i       = a;
        wdata_i      = wd;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = noise;
        mem_rdata_i  = $urandom;
        #1;
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL %s busy_c0: got %b want 1", name, busy_o); end
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL %s req_c0: got %b want 0", name, mem_req_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL %s done_c0: got %b want 0", name, done_o); end

        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            in_req = !e_fault && (c <= 1 + gd);
            n_vec++; if (mem_req_o !== in_req) begin n_err++; $display("FAIL %s req_c%0d: got %b want %b", name, c, mem_req_o, in_req); end
            if (in_req) begin
                n_vec++; if (mem_we_o !== st) begin n_err++; $display("FAIL %s we_c%0d: got %b want %b", name, c, mem_we_o, st); end
                n_vec++; if (mem_addr_o !== e_addr) begin n_err++; $display("FAIL %s addr_c%0d: got %h want %h", name, c, mem_addr_o, e_addr); end
                n_vec++; if (mem_be_o !== e_be) begin n_err++; $display("FAIL %s be_c%0d: got %b want %b", name, c, mem_be_o, e_be); end
                if (st) begin
                    n_vec++; if (mem_wdata_o !== e_wd) begin n_err++; $display("FAIL %s wdata_c%0d: got %h want %h", name, c, mem_wdata_o, e_wd); end
                end
            end
            if (c < done_cyc) begin
                n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL %s done_c%0d: got %b want 0", name, c, done_o); end
                n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL %s busy_c%0d: got %b want 1", name, c, busy_o); end
            end else begin
                n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL %s done_c%0d: got %b want 1", name, c, done_o); end
                n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL %s busy_c%0d: got %b want 0", name, c, busy_o); end
                n_vec++; if (fault_o !== e_fault) begin n_err++; $display("FAIL %s fault: got %b want %b", name, fault_o, e_fault); end
                n_vec++; if (rdata_o !== e_rd) begin n_err++; $display("FAIL %s rdata: got %h want %h", name, rdata_o, e_rd); end
            end
            // Drive the memory side for the remainder of this cycle.
            mem_gnt_i = in_req && (c == 1 + gd);
            if (!st && !e_fault && (c == done_cyc - 1)) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = word;
            end else begin
                mem_rvalid_i = noise && (c <= 1 + gd) && ($urandom_range(1, 0) == 1);
                mem_rdata_i  = $urandom;
            end
            if (c == done_cyc) begin
                valid_i      = 1'b0;
                mem_gnt_i    = 1'b0;
                mem_rvalid_i = 1'b0;
            end
        end

        if (st && !e_fault) begin
            for (int b = 0; b < 4; b++)
                if (e_be[b]) mem_model[a[7:2]][8*b +: 8] = e_wd[8*b +: 8];
        end
        $display("txn %s: %s f3=%0d addr=%h wdata=%h gnt_delay=%0d rv_delay=%0d", name,
                 st ? "store" : "load", f3, a, wd, gd, rd);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        valid_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b0; addr_i = '0; wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        repeat (2) @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done_o); end
        n_vec++; if (fault_o !== 1'b0) begin n_err++; $display("FAIL reset fault: got %b want 0", fault_o); end
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset req: got %b want 0", mem_req_o); end
        n_vec++; if (mem_we_o !== 1'b0) begin n_err++; $display("FAIL reset we: got %b want 0", mem_we_o); end
        n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset addr: got %h want 0", mem_addr_o); end
        n_vec++; if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset wdata: got %h want 0", mem_wdata_o); end
        n_vec++; if (mem_be_o !== 4'h0) begin n_err++; $display("FAIL reset be: got %b want 0", mem_be_o); end
        n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset rdata: got %h want 0", rdata_o); end
        rst_n = 1'b1;
        $display("txn reset: outputs checked");
    endtask

    task automatic test_store();
        run_access("sw_imm", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0);
        run_access("sb_lane", 1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 1'b0);
        run_access("sh_hi", 1'b1, 3'd1, 32'h10E, 32'h1234BEEF, 1, 0, 1'b0);
    endtask

    task automatic test_load_ext();
        mem_model[32'h100 >> 2] = 32'h80F07F01;
        run_access("lb_101", 1'b0, 3'd0, 32'h101, 32'h0, 0, 0, 1'b0);
        run_access("lb_103", 1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 1'b0);
        run_access("lhu_102", 1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 1'b0);
        run_access("lh_102", 1'b0, 3'd1, 32'h102, 32'h0, 0, 0, 1'b0);
        run_access("lw_100", 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_faults();
        run_access("lw_mis", 1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 1'b0);
        run_access("sh_mis", 1'b1, 3'd1, 32'h101, 32'h55AA, 0, 0, 1'b0);
        run_access("ld_f3_011", 1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 1'b0);
        run_access("st_f3_100", 1'b1, 3'd4, 32'h104, 32'h1, 0, 0, 1'b0);
    endtask

    task automatic test_stalls();
        run_access("lw_stall", 1'b0, 3'd2, 32'h108, 32'h0, 2, 1, 1'b0);
        run_access("sw_stall", 1'b1, 3'd2, 32'h10C, 32'hCAFEF00D, 3, 0, 1'b0);
        run_access("lbu_noise", 1'b0, 3'd4, 32'h10D, 32'h0, 2, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_access("b2b_sw", 1'b1, 3'd2, 32'h1F0, 32'h13579BDF, 0, 0, 1'b0);
        run_access("b2b_lw", 1'b0, 3'd2, 32'h1F0, 32'h0, 0, 0, 1'b0);
        run_access("b2b_sb", 1'b1, 3'd0, 32'h1F2, 32'h0000007E, 0, 0, 1'b0);
        run_access("b2b_lw2", 1'b0, 3'd2, 32'h1F0, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h120; wdata_i = '0;
        @(negedge clk);
        n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL rst_mid req_c1: got %b want 1", mem_req_o); end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rst_mid busy_wait: got %b want 1", busy_o); end
        rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_mid req: got %b want 0", mem_req_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid busy: got %b want 0", busy_o); end
        n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_mid addr: got %h want 0", mem_addr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_mid stray_done%0d: got %b want 0", i, done_o); end
            n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid stray_busy%0d: got %b want 0", i, busy_o); end
        end
        $display("txn reset_mid: load abandoned in WAIT");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          r;
            st = $urandom_range(1, 0);
            if (st) begin
                r  = $urandom_range(6, 0);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end else begin
                f3 = 3'($urandom_range(7, 0));
            end
            a = 32'h100 + 32'($urandom_range(63, 0)) * 4;
            if ($urandom_range(2, 0) == 0) a = a + 32'($urandom_range(3, 0));
            else if (acc_bytes(f3) == 1) a = a + 32'($urandom_range(3, 0));
            else if (acc_bytes(f3) == 2) a = a + 32'($urandom_range(1, 0)) * 2;
            run_access($sformatf("rnd%0d", i), st, f3, a, $urandom,
                       $urandom_range(3, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_store();
        test_load_ext();
        test_faults();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
